med_stream_filter: RTL and testbench

Streaming 3-tap sliding-window median filter with valid/ready handshakes on input and output. It is the sequential consumer of unsigned sample streams for the median-of-three function: it holds the last three accepted samples and emits their median once per accepted sample. The datapath is a 2-stage pipeline. It sits between a sample source and any downstream consumer that needs impulse-noise rejection.

---
 rtl/med_stream_filter.sv | 139 +++++++++++++
 tb/tb_med_stream_filter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/med_stream_filter.sv
// Streaming 3-tap sliding-window median filter with valid/ready handshakes.
// Taps feed a compare stage, which feeds a median-select stage.
module med_stream_filter #(
    parameter int DW   = 8,
    parameter bit EDGE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    win_cnt
);

    logic          adv_s;
    logic          accept_s;
    logic          seed_s;
    logic [1:0]    cnt_next_s;
    logic [DW-1:0] t0_r, t1_r, t2_r;
    logic          tv_r;
    logic [DW-1:0] a_r, b_r, c_r;
    logic          ab_r, bc_r, ac_r;
    logic          v1_r;

    function automatic logic [DW-1:0] med_sel(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b,
        input logic [DW-1:0] c,
        input logic          ab,
        input logic          bc,
        input logic          ac
    );
        if (ab == bc) begin
            return b;
        end else if (ab != ac) begin
            return a;
        end else begin
            return c;
        end
    endfunction

    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s && !flush && !rst;
    assign accept_s = in_valid && in_ready;
    assign seed_s   = EDGE && (win_cnt == 2'd0);

    // Window fill count after a potential accept.
    always_comb begin
        cnt_next_s = win_cnt;
        if (seed_s) begin
            cnt_next_s = 2'd3;
        end else if (win_cnt == 2'd3) begin
            cnt_next_s = 2'd3;
        end else begin
            cnt_next_s = win_cnt + 2'd1;
        end
    end

    // Tap shift register, fill count and "window ready" flag (tv_r).
    always_ff @(posedge clk) begin
        if (rst) begin
            t0_r    <= {DW{1'b0}};
            t1_r    <= {DW{1'b0}};
            t2_r    <= {DW{1'b0}};
            win_cnt <= 2'd0;
            tv_r    <= 1'b0;
        end else if (flush) begin
            win_cnt <= 2'd0;
            tv_r    <= 1'b0;
        end else if (adv_s) begin
            if (accept_s) begin
                if (seed_s) begin
                    t0_r <= in_data;
                    t1_r <= in_data;
                    t2_r <= in_data;
                end else begin
                    t0_r <= in_data;
                    t1_r <= t0_r;
                    t2_r <= t1_r;
                end
                win_cnt <= cnt_next_s;
                tv_r    <= (cnt_next_s == 2'd3);
            end else begin
                tv_r <= 1'b0;
            end
        end else begin
            tv_r <= tv_r;
        end
    end

    // Stage 1: capture the window and its pairwise compares.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r  <= {DW{1'b0}};
            b_r  <= {DW{1'b0}};
            c_r  <= {DW{1'b0}};
            ab_r <= 1'b0;
            bc_r <= 1'b0;
            ac_r <= 1'b0;
            v1_r <= 1'b0;
        end else if (flush) begin
            v1_r <= 1'b0;
        end else if (adv_s) begin
            a_r  <= t0_r;
            b_r  <= t1_r;
            c_r  <= t2_r;
            ab_r <= (t0_r >= t1_r);
            bc_r <= (t1_r >= t2_r);
            ac_r <= (t0_r >= t2_r);
            v1_r <= tv_r;
        end else begin
            v1_r <= v1_r;
        end
    end

    // Stage 2: select the median; data only moves when a new result arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= {DW{1'b0}};
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv_s) begin
            out_valid <= v1_r;
            if (v1_r) begin
                out_data <= med_sel(a_r, b_r, c_r, ab_r, bc_r, ac_r);
            end else begin
                out_data <= out_data;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_med_stream_filter.sv
// Bench for med_stream_filter: three instances (DW=3/EDGE=0, DW=3/EDGE=1,
// DW=5/EDGE=0) driven by shared tasks, with a queue scoreboard per instance.
module tb_med_stream_filter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst[3];
    logic       flush[3];
    logic       in_valid[3];
    logic       in_ready[3];
    logic       out_valid[3];
    logic       out_ready[3];
    logic [4:0] in_data[3];
    logic [4:0] od[3];
    logic [1:0] win_cnt[3];
    logic [2:0] od_a, od_b;
    logic [4:0] od_c;

    assign od[0] = {2'b00, od_a};
    assign od[1] = {2'b00, od_b};
    assign od[2] = od_c;

    med_stream_filter #(.DW(3), .EDGE(1'b0)) ua (
        .clk(clk), .rst(rst[0]), .flush(flush[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_data(in_data[0][2:0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(od_a), .win_cnt(win_cnt[0]));

    med_stream_filter #(.DW(3), .EDGE(1'b1)) ub (
        .clk(clk), .rst(rst[1]), .flush(flush[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_data(in_data[1][2:0]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(od_b), .win_cnt(win_cnt[1]));

    med_stream_filter #(.DW(5), .EDGE(1'b0)) uc (
        .clk(clk), .rst(rst[2]), .flush(flush[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(od_c), .win_cnt(win_cnt[2]));

    int total = 0;
    int bad   = 0;
    int q0[$], q1[$], q2[$];
    int out_cnt[3] = '{0, 0, 0};
    int m0[3], m1[3], m2[3], mcnt[3];

    typedef struct {
        int a;
        int b;
        int c;
        int m;
    } vec_t;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int med3(input int a, input int b, input int c);
        int x = a, y = b, z = c, t;
        if (x > y) begin t = x; x = y; y = t; end
        if (y > z) begin t = y; y = z; z = t; end
        if (x > y) begin t = x; x = y; y = t; end
        return y;
    endfunction

    function automatic void push(input int i, input int v);
        case (i)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int pop(input int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qclear(input int i);
        case (i)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endfunction

    // Reference window: sample accepted by instance i.
    function automatic void model_accept(input int i, input int v, input bit use_exp, input int exp);
        if (i == 1 && mcnt[i] == 0) begin
            m0[i] = v; m1[i] = v; m2[i] = v; mcnt[i] = 3;
        end else begin
            m2[i] = m1[i]; m1[i] = m0[i]; m0[i] = v;
            if (mcnt[i] < 3) mcnt[i]++;
        end
        if (mcnt[i] == 3) push(i, use_exp ? exp : med3(m0[i], m1[i], m2[i]));
    endfunction

    // Output monitor: compare every transfer against the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst[i] && out_valid[i] && out_ready[i]) begin
                out_cnt[i]++;
                if (qsize(i) == 0) check($sformatf("unexpected_out%0d", i), int'(od[i]), -1);
                else check($sformatf("out_data%0d", i), int'(od[i]), pop(i));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int v, input bit use_exp = 1'b0, input int exp = 0);
        int n = 0;
        in_valid[i] = 1'b1;
        in_data[i]  = 5'(v);
        @(negedge clk);
        while (!in_ready[i] && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready[i]) begin
            check($sformatf("accept_timeout%0d", i), int'(in_ready[i]), 1);
            in_valid[i] = 1'b0;
        end else begin
            model_accept(i, v, use_exp, exp);
            @(posedge clk);
            #1;
            in_valid[i] = 1'b0;
            check($sformatf("win_cnt%0d", i), int'(win_cnt[i]), mcnt[i]);
        end
    endtask

    task automatic do_flush(input int i);
        flush[i] = 1'b1;
        @(negedge clk);
        check($sformatf("flush_ready%0d", i), int'(in_ready[i]), 0);
        @(posedge clk);
        #1;
        flush[i] = 1'b0;
        qclear(i);
        mcnt[i] = 0;
        check($sformatf("flush_wincnt%0d", i), int'(win_cnt[i]), 0);
        check($sformatf("flush_valid%0d", i), int'(out_valid[i]), 0);
    endtask

    task automatic drain(input int i);
        idle(6);
        check($sformatf("drain_q%0d", i), qsize(i), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   c0;

        tbl[0] = '{4, 4, 1, 4};
        tbl[1] = '{0, 0, 0, 0};
        tbl[2] = '{7, 0, 3, 3};
        tbl[3] = '{1, 7, 7, 7};
        tbl[4] = '{7, 7, 7, 7};
        tbl[5] = '{0, 7, 0, 0};
        tbl[6] = '{5, 1, 3, 3};
        tbl[7] = '{2, 6, 4, 4};

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; flush[i] = 1'b0; in_valid[i] = 1'b0;
            in_data[i] = 5'd0; out_ready[i] = 1'b1; mcnt[i] = 0;
            m0[i] = 0; m1[i] = 0; m2[i] = 0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_valid", int'(out_valid[i]), 0);
            check("rst_data", int'(od[i]), 0);
            check("rst_wincnt", int'(win_cnt[i]), 0);
            check("rst_ready", int'(in_ready[i]), 0);
            rst[i] = 1'b0;
        end

        // Basic EDGE=0 stream: outputs 3,3,6.
        c0 = out_cnt[0];
        send(0, 5); send(0, 1); send(0, 3); send(0, 7); send(0, 6);
        drain(0);
        check("basic_count", out_cnt[0] - c0, 3);

        // EDGE=0 latency: first output two edges after the third accept.
        do_flush(0);
        send(0, 5); send(0, 1); send(0, 3);
        check("lat0_k", int'(out_valid[0]), 0);
        idle(1);
        check("lat0_k1", int'(out_valid[0]), 0);
        idle(1);
        check("lat0_k2", int'(out_valid[0]), 1);
        drain(0);

        // EDGE=1 stream 2,7,0,5: outputs 2,2,2,5, first two edges after accept.
        do_flush(1);
        c0 = out_cnt[1];
        send(1, 2);
        check("lat1_k", int'(out_valid[1]), 0);
        idle(1);
        check("lat1_k1", int'(out_valid[1]), 0);
        idle(1);
        check("lat1_k2", int'(out_valid[1]), 1);
        send(1, 7); send(1, 0); send(1, 5, 1'b1, 5);
        drain(1);
        check("edge1_count", out_cnt[1] - c0, 4);

        // Table of windows with hand-computed medians.
        for (int k = 0; k < 8; k++) begin
            do_flush(0);
            send(0, tbl[k].a); send(0, tbl[k].b); send(0, tbl[k].c, 1'b1, tbl[k].m);
            idle(2);
        end
        drain(0);

        // Exhaustive DW=3 windows.
        c0 = out_cnt[0];
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                for (int z = 0; z < 8; z++) begin
                    do_flush(0);
                    send(0, x); send(0, y); send(0, z);
                    idle(2);
                end
        drain(0);
        check("exhaustive_count", out_cnt[0] - c0, 512);

        // Backpressure: 1..20 with a 4-cycle stall.
        do_flush(2);
        c0 = out_cnt[2];
        fork
            begin
                for (int v = 1; v <= 20; v++) send(2, v);
            end
            begin : stall_thread
                logic [4:0] held;
                int n;
                n = 0;
                while (!out_valid[2] && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("stall_seen", int'(out_valid[2]), 1);
                if (out_valid[2]) begin
                    out_ready[2] = 1'b0;
                    held = od[2];
                    repeat (4) begin
                        @(negedge clk);
                        check("stall_hold", int'(od[2]), int'(held));
                        check("stall_ready", int'(in_ready[2]), 0);
                    end
                    @(posedge clk);
                    #1;
                    out_ready[2] = 1'b1;
                end
            end
        join
        drain(2);
        check("stall_count", out_cnt[2] - c0, 18);

        // Flush mid-stream: only 6 survives.
        do_flush(0);
        c0 = out_cnt[0];
        send(0, 5); send(0, 1);
        do_flush(0);
        send(0, 3); send(0, 7); send(0, 6, 1'b1, 6);
        drain(0);
        check("flush_count", out_cnt[0] - c0, 1);

        // Reset while a result is stalled on the output.
        do_flush(2);
        out_ready[2] = 1'b0;
        send(2, 1); send(2, 2); send(2, 3);
        idle(3);
        check("pre_rst_valid", int'(out_valid[2]), 1);
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", int'(out_valid[2]), 0);
        check("mid_rst_data", int'(od[2]), 0);
        check("mid_rst_wincnt", int'(win_cnt[2]), 0);
        check("mid_rst_ready", int'(in_ready[2]), 0);
        rst[2] = 1'b0;
        qclear(2);
        mcnt[2] = 0;
        out_ready[2] = 1'b1;
        c0 = out_cnt[2];
        send(2, 9); send(2, 9); send(2, 4, 1'b1, 9);
        drain(2);
        check("rst_count", out_cnt[2] - c0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
